// File: rtl/output_unit_tx.sv
// output_unit_tx: router output-port transmitter. Buffers whole packets in a store-and-forward FIFO,
// then requests the downstream input unit and streams each packet one flit per cycle.
// Optional ack timeout/backoff enabled by defining OUTPUT_TX_ACK_TIMEOUT_EN.
`default_nettype none

module output_unit_tx #(
    parameter int FLIT_SIZE   = 32,
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [FLIT_SIZE-1:0] i_flit,
    input  logic                 i_flit_valid,
    output logic                 o_ready,
    output logic                 o_downstream_req,
    input  logic                 i_transmit_ack,
    output logic [FLIT_SIZE-1:0] o_flit,
    output logic                 o_busy,
    output logic                 o_pkt_sent,
    output logic                 o_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0]  TAIL_FLIT = 2'b10;
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] CNT_ZERO  = '0;

`ifdef OUTPUT_TX_ACK_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SEND = 2'd2, BACKOFF = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SEND = 2'd2} state_t;
`endif

    state_t state, state_next;

    // The valid bit is not stored: every flit in the buffer is valid by construction.
    logic [FLIT_SIZE-2:0] mem [DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic [AW:0]          pkt_cnt, pkt_cnt_next;
    logic                 full, empty;
    logic                 wr_en, wr_tail;
    logic                 pop, pop_tail;
    logic                 ack_timeout;
    logic [FLIT_SIZE-2:0] head;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign o_ready = !full;
    assign o_busy  = (state != IDLE);

    assign wr_en   = i_flit_valid && !full && i_flit[FLIT_SIZE-1];
    assign wr_tail = wr_en && (i_flit[FLIT_SIZE-2:FLIT_SIZE-3] == TAIL_FLIT);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= i_flit[FLIT_SIZE-2:0];
        end
    end

`ifdef OUTPUT_TX_ACK_TIMEOUT_EN
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    logic [TW-1:0] to_cnt;

    // Restarts from zero every time REQ is (re)entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (state == REQ) begin
            to_cnt <= to_cnt + TW'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    // An ack in the expiry cycle takes priority over the timeout.
    assign ack_timeout = (state == REQ) && !i_transmit_ack && (to_cnt == TO_LAST);
`else
    assign ack_timeout = 1'b0;
`endif

    assign o_timeout = ack_timeout;

    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        pop_tail     = 1'b0;
        pkt_cnt_next = pkt_cnt;
        unique case (state)
            IDLE: begin
                if (pkt_cnt != CNT_ZERO) state_next = REQ;
            end
            REQ: begin
                if (i_transmit_ack) begin
                    pop        = !empty;
                    state_next = SEND;
                end else if (ack_timeout) begin
`ifdef OUTPUT_TX_ACK_TIMEOUT_EN
                    state_next = BACKOFF;
`endif
                end
            end
            SEND: begin
                pop = !empty;
            end
`ifdef OUTPUT_TX_ACK_TIMEOUT_EN
            BACKOFF: begin
                state_next = REQ;
            end
`endif
            default: state_next = IDLE;
        endcase
        pop_tail     = pop && (head[FLIT_SIZE-2:FLIT_SIZE-3] == TAIL_FLIT);
        pkt_cnt_next = pkt_cnt + {{AW{1'b0}}, wr_tail} - {{AW{1'b0}}, pop_tail};
        // A tail leaving ends the packet; a tail arriving in that same cycle keeps us requesting.
        if (pop_tail) begin
            state_next = (pkt_cnt_next != CNT_ZERO) ? REQ : IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            pkt_cnt          <= '0;
            o_flit           <= '0;
            o_pkt_sent       <= 1'b0;
            o_downstream_req <= 1'b0;
        end else begin
            state            <= state_next;
            pkt_cnt          <= pkt_cnt_next;
            o_flit           <= pop ? {1'b1, head} : '0;
            o_pkt_sent       <= pop_tail;
            o_downstream_req <= (state_next == REQ);
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

`ifndef SYNTHESIS
    a_no_write_full: assert property (@(posedge clk) disable iff (!reset_n) !(wr_en && full));
    a_send_not_empty: assert property (@(posedge clk) disable iff (!reset_n) !(state == SEND && empty));
    a_params: assert property (@(posedge clk) ((DEPTH & (DEPTH - 1)) == 0) && (ACK_TIMEOUT > 1));
`endif

endmodule

`default_nettype wire

// File: tb/tb_output_unit_tx.sv
// tb_output_unit_tx: directed self-checking bench for output_unit_tx (FLIT_SIZE=32, DEPTH=16, ACK_TIMEOUT=8).
`default_nettype none

module tb_output_unit_tx;

    localparam logic [1:0] HEAD = 2'b00;
    localparam logic [1:0] BODY = 2'b01;
    localparam logic [1:0] TAIL = 2'b10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] i_flit = '0;
    logic        i_flit_valid = 1'b0;
    logic        o_ready;
    logic        o_downstream_req;
    logic        i_transmit_ack = 1'b0;
    logic [31:0] o_flit;
    logic        o_busy;
    logic        o_pkt_sent;
    logic        o_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    output_unit_tx #(.FLIT_SIZE(32), .DEPTH(16), .ACK_TIMEOUT(8)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_flit           (i_flit),
        .i_flit_valid     (i_flit_valid),
        .o_ready          (o_ready),
        .o_downstream_req (o_downstream_req),
        .i_transmit_ack   (i_transmit_ack),
        .o_flit           (o_flit),
        .o_busy           (o_busy),
        .o_pkt_sent       (o_pkt_sent),
        .o_timeout        (o_timeout)
    );

    function automatic logic [31:0] mk(input logic [1:0] t, input int p);
        return {1'b1, t, 29'(p)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_flit(input logic [31:0] f);
        i_flit       = f;
        i_flit_valid = 1'b1;
        tick();
        i_flit_valid = 1'b0;
        i_flit       = '0;
    endtask

    task automatic do_reset();
        i_flit_valid   = 1'b0;
        i_transmit_ack = 1'b0;
        reset_n        = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_req(input string tag);
        for (int n = 0; n < 20 && !o_downstream_req; n++) tick();
        chk(tag, {31'd0, o_downstream_req}, 32'd1);
    endtask

    task automatic ack_once();
        i_transmit_ack = 1'b1;
        tick();
        i_transmit_ack = 1'b0;
    endtask

    logic [31:0] exp_f [16];

    initial begin
        // Reset state
        do_reset();
        chk("rst_flit", o_flit, 32'd0);
        chk("rst_req", {31'd0, o_downstream_req}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_sent", {31'd0, o_pkt_sent}, 32'd0);
        chk("rst_timeout", {31'd0, o_timeout}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);

        // Basic 4-flit packet, req latency, ack two cycles after req
        exp_f[0] = mk(HEAD, 'h11); exp_f[1] = mk(BODY, 'h22);
        exp_f[2] = mk(BODY, 'h33); exp_f[3] = mk(TAIL, 'h44);
        for (int i = 0; i < 4; i++) write_flit(exp_f[i]);
        chk("lat_req_t1", {31'd0, o_downstream_req}, 32'd0);
        tick();
        chk("lat_req_t2", {31'd0, o_downstream_req}, 32'd1);
        chk("req_busy", {31'd0, o_busy}, 32'd1);
        tick();
        chk("req_hold", {31'd0, o_downstream_req}, 32'd1);
        ack_once();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("p2_flit%0d", i), o_flit, exp_f[i]);
            chk($sformatf("p2_req%0d", i), {31'd0, o_downstream_req}, 32'd0);
            chk($sformatf("p2_sent%0d", i), {31'd0, o_pkt_sent}, (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        chk("p2_idle_flit", o_flit, 32'd0);
        chk("p2_idle_sent", {31'd0, o_pkt_sent}, 32'd0);
        chk("p2_idle_busy", {31'd0, o_busy}, 32'd0);

        // Flit with valid bit clear is ignored
        write_flit(mk(TAIL, 'h55) & 32'h7fff_ffff);
        repeat (3) tick();
        chk("inval_req", {31'd0, o_downstream_req}, 32'd0);
        chk("inval_busy", {31'd0, o_busy}, 32'd0);

        // Fill to DEPTH, drop the extra flit, then four req/ack rounds
        for (int i = 0; i < 16; i++)
            exp_f[i] = mk((i % 4 == 0) ? HEAD : (i % 4 == 3) ? TAIL : BODY, 'h100 + i);
        for (int i = 0; i < 16; i++) write_flit(exp_f[i]);
        chk("full_ready", {31'd0, o_ready}, 32'd0);
        write_flit(mk(TAIL, 'h1ff));
        wait_req("full_req");
        for (int p = 0; p < 4; p++) begin
            ack_once();
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("fill_flit%0d", p * 4 + i), o_flit, exp_f[p * 4 + i]);
                if (i < 3) tick();
            end
            chk($sformatf("fill_sent%0d", p), {31'd0, o_pkt_sent}, 32'd1);
            chk($sformatf("fill_reack_req%0d", p), {31'd0, o_downstream_req}, (p < 3) ? 32'd1 : 32'd0);
        end
        tick();
        chk("fill_end_flit", o_flit, 32'd0);
        repeat (3) tick();
        chk("drop_no_req", {31'd0, o_downstream_req}, 32'd0);
        chk("drop_ready", {31'd0, o_ready}, 32'd1);

        // Tail of B written in the same cycle tail of A is popped
        write_flit(mk(HEAD, 'h201));
        write_flit(mk(BODY, 'h202));
        write_flit(mk(TAIL, 'h203));
        write_flit(mk(HEAD, 'h301));
        chk("ab_req", {31'd0, o_downstream_req}, 32'd1);
        i_flit = mk(BODY, 'h302); i_flit_valid = 1'b1; i_transmit_ack = 1'b1;
        tick();
        i_flit_valid = 1'b0; i_transmit_ack = 1'b0;
        chk("ab_a0", o_flit, mk(HEAD, 'h201));
        tick();
        chk("ab_a1", o_flit, mk(BODY, 'h202));
        write_flit(mk(TAIL, 'h303));
        chk("ab_a2", o_flit, mk(TAIL, 'h203));
        chk("ab_a_sent", {31'd0, o_pkt_sent}, 32'd1);
        chk("ab_req_after_a", {31'd0, o_downstream_req}, 32'd1);
        ack_once();
        chk("ab_b0", o_flit, mk(HEAD, 'h301));
        tick();
        chk("ab_b1", o_flit, mk(BODY, 'h302));
        tick();
        chk("ab_b2", o_flit, mk(TAIL, 'h303));
        chk("ab_b_sent", {31'd0, o_pkt_sent}, 32'd1);
        chk("ab_b_req", {31'd0, o_downstream_req}, 32'd0);
        chk("ab_b_busy", {31'd0, o_busy}, 32'd0);
        tick();

        // Asynchronous reset in the middle of SEND with three flits still buffered
        for (int i = 0; i < 4; i++) write_flit(mk((i == 0) ? HEAD : (i == 3) ? TAIL : BODY, 'h400 + i));
        wait_req("mid_req");
        ack_once();
        chk("mid_first", o_flit, mk(HEAD, 'h400));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_flit", o_flit, 32'd0);
        chk("mid_rst_req", {31'd0, o_downstream_req}, 32'd0);
        chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_rst_sent", {31'd0, o_pkt_sent}, 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        chk("mid_after_req", {31'd0, o_downstream_req}, 32'd0);
        chk("mid_after_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_after_flit", o_flit, 32'd0);

`ifdef OUTPUT_TX_ACK_TIMEOUT_EN
        // Ack timeout: pulse in the 8th REQ cycle, one BACKOFF cycle, then REQ again
        write_flit(mk(HEAD, 'h501));
        write_flit(mk(TAIL, 'h502));
        wait_req("to_req");
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("to_pulse%0d", k), {31'd0, o_timeout}, (k == 8) ? 32'd1 : 32'd0);
            chk($sformatf("to_req%0d", k), {31'd0, o_downstream_req}, 32'd1);
            tick();
        end
        chk("bo_req", {31'd0, o_downstream_req}, 32'd0);
        chk("bo_timeout", {31'd0, o_timeout}, 32'd0);
        chk("bo_busy", {31'd0, o_busy}, 32'd1);
        tick();
        chk("re_req", {31'd0, o_downstream_req}, 32'd1);
        chk("re_timeout", {31'd0, o_timeout}, 32'd0);
        ack_once();
        chk("to_f0", o_flit, mk(HEAD, 'h501));
        tick();
        chk("to_f1", o_flit, mk(TAIL, 'h502));
        chk("to_sent", {31'd0, o_pkt_sent}, 32'd1);
        tick();
`else
        // Without the timeout option REQ waits indefinitely
        write_flit(mk(HEAD, 'h501));
        write_flit(mk(TAIL, 'h502));
        wait_req("nto_req");
        repeat (80) tick();
        chk("nto_req_hold", {31'd0, o_downstream_req}, 32'd1);
        chk("nto_timeout", {31'd0, o_timeout}, 32'd0);
        ack_once();
        chk("nto_f0", o_flit, mk(HEAD, 'h501));
        tick();
        chk("nto_f1", o_flit, mk(TAIL, 'h502));
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
